// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the single-bus CPU datapath.
//   - ALU opcodes (5-bit `operation` encodings)
//   - Bus-source indices into the 32-bit encoder request vector
//   - IR field bit positions used by select-and-encode and the C source
package cpu_pkg;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  // Bits 0..15 of the request vector are R0..R15.
  localparam logic [4:0] SrcHi     = 5'd16;
  localparam logic [4:0] SrcLo     = 5'd17;
  localparam logic [4:0] SrcZHigh  = 5'd18;
  localparam logic [4:0] SrcZLow   = 5'd19;
  localparam logic [4:0] SrcPc     = 5'd20;
  localparam logic [4:0] SrcMdr    = 5'd21;
  localparam logic [4:0] SrcInPort = 5'd22;
  localparam logic [4:0] SrcC      = 5'd23;

  localparam int unsigned IrRaLsb = 23;
  localparam int unsigned IrRbLsb = 19;
  localparam int unsigned IrRcLsb = 15;
  localparam int unsigned IrFieldW = 4;
  localparam int unsigned IrCMsb  = 18;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU, A = Y register, B = bus.
// Ports:
//   a_i, b_i      operands
//   operation_i   5-bit opcode (see cpu_pkg)
//   force_and_i   overrides the opcode with AND
//   result_o      {ZHigh, ZLow}; ZHigh is zero except for MUL/DIV
// Optional feature: define MUL_DIV_EN to enable signed MUL and DIV opcodes;
// without it those opcodes produce 0 like any other unused code.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [4:0]         operation_i,
  input  logic               force_and_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] ror_full;
  logic [2*WIDTH-1:0] rol_full;
  logic [4:0]         op;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;

  // Rotates as shifts of A concatenated with itself.
  assign sh       = b_i[ShW-1:0];
  assign dbl      = {a_i, a_i};
  assign ror_full = dbl >> sh;
  assign rol_full = dbl << sh;
  assign op       = force_and_i ? OpAnd : operation_i;

`ifdef MUL_DIV_EN
  logic signed [2*WIDTH-1:0] prod;
  assign prod = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
`endif

  always_comb begin
    lo = '0;
    hi = '0;
    case (op)
      OpAdd:  lo = a_i + b_i;
      OpSub:  lo = a_i - b_i;
      OpAnd:  lo = a_i & b_i;
      OpOr:   lo = a_i | b_i;
      OpRor:  lo = ror_full[WIDTH-1:0];
      OpRol:  lo = rol_full[2*WIDTH-1:WIDTH];
      OpShr:  lo = a_i >> sh;
      OpShra: lo = $signed(a_i) >>> sh;
      OpShl:  lo = a_i << sh;
      OpNeg:  lo = -b_i;
      OpNot:  lo = ~b_i;
`ifdef MUL_DIV_EN
      OpMul: begin
        lo = prod[WIDTH-1:0];
        hi = prod[2*WIDTH-1:WIDTH];
      end
      OpDiv: begin
        if (b_i == '0) begin
          lo = '1;
          hi = a_i;
        end else begin
          lo = $signed(a_i) / $signed(b_i);
          hi = $signed(a_i) % $signed(b_i);
        end
      end
`endif
      default: ;
    endcase
  end

  assign result_o = {hi, lo};

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath, one micro-step per Clock.
// Ports:
//   Clock, Resetn                 clock, synchronous active-low reset
//   PCout..InPortout              bus-drive requests (highest source index wins)
//   MARin..LOin, Rin              register load enables
//   IncPC, Read, AND              PC increment, MDR source, ALU AND override
//   GRA/GRB/GRC, Rout, BAout      IR-field register select and drive
//   Mdatain, InPort_data          memory read data, external input port
//   operation                     ALU opcode
//   Register_enable_Signals       direct one-hot loads for R0..R15
//   encoder_input, bus_data       bus request vector and bus value (debug)
//   MAR_out                       memory address
// Optional feature: MUL_DIV_EN enables MUL/DIV in cpu_alu.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             ZHighout,
  input  logic             LOout,
  input  logic             HIout,
  input  logic             Cout,
  input  logic             InPortout,
  input  logic             MARin,
  input  logic             Zin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic             GRA,
  input  logic             GRB,
  input  logic             GRC,
  input  logic             Rin,
  input  logic             Rout,
  input  logic             BAout,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] InPort_data,
  input  logic [NREG-1:0]  Register_enable_Signals,
  output logic [31:0]      encoder_input,
  output logic [WIDTH-1:0] bus_data,
  output logic [WIDTH-1:0] MAR_out
);

  logic [WIDTH-1:0]   r_q [NREG];
  logic [WIDTH-1:0]   pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, inport_q;
  logic [2*WIDTH-1:0] z_q;

  logic [IrFieldW-1:0] sel_idx;
  logic [NREG-1:0]     reg_dec, reg_drive, reg_load;
  logic [31:0]         enc;
  logic [4:0]          bus_idx;
  logic [WIDTH-1:0]    bus, c_ext;
  logic [2*WIDTH-1:0]  alu_result;

  // Select-and-encode from the IR register fields.
  assign sel_idx = ({IrFieldW{GRA}} & ir_q[IrRaLsb +: IrFieldW])
                 | ({IrFieldW{GRB}} & ir_q[IrRbLsb +: IrFieldW])
                 | ({IrFieldW{GRC}} & ir_q[IrRcLsb +: IrFieldW]);

  always_comb begin
    reg_dec          = '0;
    reg_dec[sel_idx] = 1'b1;
  end

  assign reg_drive = reg_dec & {NREG{Rout | BAout}};
  assign reg_load  = (reg_dec & {NREG{Rin}}) | Register_enable_Signals;
  assign c_ext     = {{(WIDTH-IrCMsb-1){ir_q[IrCMsb]}}, ir_q[IrCMsb:0]};

  always_comb begin
    enc                = '0;
    enc[NREG-1:0]      = reg_drive;
    enc[SrcHi]         = HIout;
    enc[SrcLo]         = LOout;
    enc[SrcZHigh]      = ZHighout;
    enc[SrcZLow]       = Zlowout;
    enc[SrcPc]         = PCout;
    enc[SrcMdr]        = MDRout;
    enc[SrcInPort]     = InPortout;
    enc[SrcC]          = Cout;
  end

  // Priority encoder: later (higher) set bits overwrite earlier ones.
  always_comb begin
    bus_idx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (enc[i]) bus_idx = 5'(i);
    end
  end

  always_comb begin
    bus = '0;
    if (|enc) begin
      case (bus_idx)
        SrcHi:     bus = hi_q;
        SrcLo:     bus = lo_q;
        SrcZHigh:  bus = z_q[2*WIDTH-1:WIDTH];
        SrcZLow:   bus = z_q[WIDTH-1:0];
        SrcPc:     bus = pc_q;
        SrcMdr:    bus = mdr_q;
        SrcInPort: bus = inport_q;
        SrcC:      bus = c_ext;
        default: begin
          // BAout turns R0 into a constant zero base address.
          if (bus_idx < 5'(NREG) && !(bus_idx == 5'd0 && BAout)) begin
            bus = r_q[bus_idx[IrFieldW-1:0]];
          end
        end
      endcase
    end
  end

  cpu_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i        (y_q),
    .b_i        (bus),
    .operation_i(operation),
    .force_and_i(AND),
    .result_o   (alu_result)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_load[i]) r_q[i] <= bus;
      end
      if (PCin)  pc_q  <= IncPC ? pc_q + WIDTH'(1) : bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (IRin)  ir_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (Zin)   z_q   <= alu_result;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (MARin) mar_q <= bus;
      inport_q <= InPort_data;
    end
  end

  assign encoder_input = enc;
  assign bus_data      = bus;
  assign MAR_out       = mar_q;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  logic Clock = 1'b0;
  logic Resetn;
  logic PCout, Zlowout, MDRout, ZHighout, LOout, HIout, Cout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read, AND, GRA, GRB, GRC, Rin, Rout, BAout;
  logic [31:0] Mdatain, InPort_data;
  logic [4:0]  operation;
  logic [15:0] Register_enable_Signals;
  logic [31:0] encoder_input, bus_data, MAR_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_r [16];

  cpu_datapath dut (
    .Clock(Clock), .Resetn(Resetn),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .ZHighout(ZHighout),
    .LOout(LOout), .HIout(HIout), .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .AND(AND),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Mdatain(Mdatain), .operation(operation), .InPort_data(InPort_data),
    .Register_enable_Signals(Register_enable_Signals),
    .encoder_input(encoder_input), .bus_data(bus_data), .MAR_out(MAR_out)
  );

  always #5 Clock = ~Clock;

  // Reference ALU written from the opcode table.
  function automatic logic [63:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [4:0] op,
                                          logic and_f);
    logic [31:0] r;
    int s;
    s = int'(b[4:0]);
    r = a;
    if (and_f) return {32'h0, a & b};
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin for (int k = 0; k < s; k++) r = {r[0], r[31:1]}; return {32'h0, r}; end
      5'd8:  begin for (int k = 0; k < s; k++) r = {r[30:0], r[31]}; return {32'h0, r}; end
      5'd9:  return {32'h0, a >> s};
      5'd10: begin for (int k = 0; k < s; k++) r = {r[31], r[31:1]}; return {32'h0, r}; end
      5'd11: return {32'h0, a << s};
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, ~b};
`ifdef MUL_DIV_EN
      5'd15: return 64'(longint'(int'(a)) * longint'(int'(b)));
      5'd16: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
      end
`endif
      default: return 64'h0;
    endcase
  endfunction

  task automatic clear_ctrl();
    {PCout, Zlowout, MDRout, ZHighout, LOout, HIout, Cout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
    {IncPC, Read, AND, GRA, GRB, GRC, Rin, Rout, BAout} = '0;
    operation = 5'd0;
    Register_enable_Signals = 16'h0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    clear_ctrl();
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
    clear_ctrl();
  endtask

  task automatic write_reg(input int idx, input logic [31:0] v);
    mdr_load(v);
    MDRout = 1'b1;
    Register_enable_Signals[idx] = 1'b1;
    tick();
    clear_ctrl();
    model_r[idx] = v;
  endtask

  task automatic set_ir(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    clear_ctrl();
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    logic [3:0] f;
    f = 4'(idx);
    set_ir({5'b0, f, 23'b0});
    GRA = 1'b1; Rout = 1'b1;
    #1;
    v = bus_data;
    clear_ctrl();
  endtask

  task automatic run_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic and_f, output logic [63:0] z);
    mdr_load(a);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    mdr_load(b);
    MDRout = 1'b1; operation = op; AND = and_f; Zin = 1'b1;
    tick();
    clear_ctrl();
    Zlowout = 1'b1;
    #1 z[31:0] = bus_data;
    clear_ctrl();
    ZHighout = 1'b1;
    #1 z[63:32] = bus_data;
    clear_ctrl();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    write_reg(5, 32'hDEAD_BEEF);
    mdr_load(32'hFFF7_1234);
    MDRout = 1'b1; PCin = 1'b1; HIin = 1'b1; LOin = 1'b1; MARin = 1'b1; IRin = 1'b1;
    Yin = 1'b1;
    tick();
    clear_ctrl();
    MDRout = 1'b1; operation = 5'd3; Zin = 1'b1;
    tick();
    clear_ctrl();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    checks++;
    if (bus_data !== 32'h0) begin
      errors++; $display("FAIL reset_idle_bus got %h expected 00000000", bus_data);
    end
    checks++;
    if (MAR_out !== 32'h0) begin
      errors++; $display("FAIL reset_mar got %h expected 00000000", MAR_out);
    end
    for (int i = 0; i < 8; i++) begin
      clear_ctrl();
      case (i)
        0: PCout = 1'b1;
        1: MDRout = 1'b1;
        2: HIout = 1'b1;
        3: LOout = 1'b1;
        4: Zlowout = 1'b1;
        5: ZHighout = 1'b1;
        6: Cout = 1'b1;
        default: InPortout = 1'b1;
      endcase
      #1;
      checks++;
      if (bus_data !== 32'h0) begin
        errors++; $display("FAIL reset_source%0d got %h expected 00000000", i, bus_data);
      end
    end
    clear_ctrl();
    for (int i = 0; i < 16; i++) model_r[i] = 32'h0;
    read_reg(5, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_r5 got %h expected 00000000", v);
    end
  endtask

  task automatic test_load();
    logic [31:0] v;
    write_reg(3, 32'h22);
    write_reg(7, 32'h24);
    write_reg(4, 32'h28);
    read_reg(3, v);
    checks++;
    if (v !== 32'h22) begin errors++; $display("FAIL load_r3 got %h expected 00000022", v); end
    read_reg(7, v);
    checks++;
    if (v !== 32'h24) begin errors++; $display("FAIL load_r7 got %h expected 00000024", v); end
    read_reg(4, v);
    checks++;
    if (v !== 32'h28) begin errors++; $display("FAIL load_r4 got %h expected 00000028", v); end
  endtask

  task automatic test_and_instr();
    logic [31:0] v;
    clear_ctrl();
    PCout = 1'b1; MARin = 1'b1;
    tick();
    clear_ctrl();
    checks++;
    if (MAR_out !== 32'h0) begin errors++; $display("FAIL fetch_mar got %h expected 0", MAR_out); end
    PCin = 1'b1; IncPC = 1'b1;
    tick();
    clear_ctrl();
    PCout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h1) begin errors++; $display("FAIL fetch_pc got %h expected 1", bus_data); end
    clear_ctrl();
    set_ir(32'h2A1B_8000);
    GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
    tick();
    clear_ctrl();
    GRC = 1'b1; Rout = 1'b1; operation = 5'b00101; Zin = 1'b1;
    tick();
    clear_ctrl();
    Zlowout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h20) begin errors++; $display("FAIL and_zlow got %h expected 20", bus_data); end
    GRA = 1'b1; Rin = 1'b1;
    tick();
    clear_ctrl();
    model_r[4] = 32'h20;
    read_reg(4, v);
    checks++;
    if (v !== 32'h20) begin errors++; $display("FAIL and_r4 got %h expected 20", v); end
  endtask

  task automatic test_baout();
    write_reg(0, 32'h5);
    set_ir(32'h0);
    GRB = 1'b1; BAout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h0) begin errors++; $display("FAIL baout_r0 got %h expected 0", bus_data); end
    checks++;
    if (encoder_input !== 32'h1) begin
      errors++; $display("FAIL baout_enc got %h expected 00000001", encoder_input);
    end
    clear_ctrl();
    GRB = 1'b1; Rout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h5) begin errors++; $display("FAIL rout_r0 got %h expected 5", bus_data); end
    clear_ctrl();
  endtask

  task automatic test_priority();
    mdr_load(32'hA5A5_0001);
    PCout = 1'b1; MDRout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL prio_bus got %h expected a5a50001", bus_data);
    end
    checks++;
    if (encoder_input !== 32'h0030_0000) begin
      errors++; $display("FAIL prio_enc got %h expected 00300000", encoder_input);
    end
    clear_ctrl();
  endtask

  task automatic test_c_and_io();
    logic [31:0] ir, exp;
    for (int i = 0; i < 4; i++) begin
      ir = $urandom;
      exp = (ir[18]) ? (32'(ir[18:0]) | 32'hFFF8_0000) : 32'(ir[18:0]);
      set_ir(ir);
      Cout = 1'b1;
      #1;
      checks++;
      if (bus_data !== exp) begin
        errors++; $display("FAIL c_sext got %h expected %h", bus_data, exp);
      end
      clear_ctrl();
      exp = $urandom;
      mdr_load(exp);
      MDRout = 1'b1;
      if (i[0]) HIin = 1'b1; else LOin = 1'b1;
      tick();
      clear_ctrl();
      if (i[0]) HIout = 1'b1; else LOout = 1'b1;
      #1;
      checks++;
      if (bus_data !== exp) begin
        errors++; $display("FAIL hilo%0d got %h expected %h", i, bus_data, exp);
      end
      clear_ctrl();
      exp = $urandom;
      InPort_data = exp;
      tick();
      InPortout = 1'b1;
      #1;
      checks++;
      if (bus_data !== exp) begin
        errors++; $display("FAIL inport got %h expected %h", bus_data, exp);
      end
      clear_ctrl();
      exp = $urandom;
      mdr_load(exp);
      MDRout = 1'b1; PCin = 1'b1;
      tick();
      clear_ctrl();
      PCout = 1'b1;
      #1;
      checks++;
      if (bus_data !== exp) begin
        errors++; $display("FAIL pc_bus_load got %h expected %h", bus_data, exp);
      end
      clear_ctrl();
    end
  endtask

  task automatic test_alu_sweep();
    logic [63:0] z;
    logic [4:0]  ops [5];
    logic [63:0] exps [5];
    ops = '{5'd3, 5'd4, 5'd10, 5'd8, 5'd18};
    exps = '{64'h8000_0002, 64'h8000_0000, 64'hC000_0000, 64'h3, 64'hFFFF_FFFE};
    for (int i = 0; i < 5; i++) begin
      run_alu(32'h8000_0001, 32'h1, ops[i], 1'b0, z);
      checks++;
      if (z !== exps[i]) begin
        errors++; $display("FAIL alu_sweep op%0d got %h expected %h", ops[i], z, exps[i]);
      end
    end
    run_alu(32'hFFFF_FFFD, 32'h4, 5'd15, 1'b0, z);
    checks++;
`ifdef MUL_DIV_EN
    if (z !== 64'hFFFF_FFFF_FFFF_FFF4) begin
      errors++; $display("FAIL alu_mul got %h expected fffffffffffffff4", z);
    end
`else
    if (z !== 64'h0) begin errors++; $display("FAIL alu_mul_off got %h expected 0", z); end
`endif
    run_alu(32'h0000_0007, 32'h0, 5'd16, 1'b0, z);
    checks++;
`ifdef MUL_DIV_EN
    if (z !== 64'h0000_0007_FFFF_FFFF) begin
      errors++; $display("FAIL alu_div0 got %h expected 00000007ffffffff", z);
    end
`else
    if (z !== 64'h0) begin errors++; $display("FAIL alu_div_off got %h expected 0", z); end
`endif
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b;
    logic [4:0]  op;
    logic        and_f;
    logic [63:0] z, exp;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      op = 5'($urandom_range(0, 31));
      and_f = ($urandom_range(0, 7) == 0);
      if (op == 5'd16 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'h1;
      exp = alu_ref(a, b, op, and_f);
      run_alu(a, b, op, and_f, z);
      checks++;
      if (z !== exp) begin
        errors++;
        $display("FAIL alu_rand op=%0d and=%0b a=%h b=%h got %h expected %h",
                 op, and_f, a, b, z, exp);
      end
    end
  endtask

  task automatic test_regfile_random();
    logic [31:0] v;
    for (int i = 0; i < 24; i++) write_reg(int'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== model_r[i]) begin
        errors++; $display("FAIL regfile_r%0d got %h expected %h", i, v, model_r[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    mdr_load(32'h1234_5678);
    Resetn = 1'b0;
    Mdatain = 32'hCAFE_F00D; Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1;
    tick();
    Resetn = 1'b1;
    clear_ctrl();
    MDRout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h0) begin errors++; $display("FAIL midreset_mdr got %h expected 0", bus_data); end
    clear_ctrl();
    PCout = 1'b1;
    #1;
    checks++;
    if (bus_data !== 32'h0) begin errors++; $display("FAIL midreset_pc got %h expected 0", bus_data); end
    clear_ctrl();
  endtask

  initial begin
    clear_ctrl();
    Resetn = 1'b0;
    Mdatain = 32'h0;
    InPort_data = 32'h0;
    tick();
    tick();
    Resetn = 1'b1;
    test_reset();
    test_load();
    test_and_instr();
    test_baout();
    test_priority();
    test_c_and_io();
    test_alu_sweep();
    test_alu_random();
    test_regfile_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
